// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment pattern constants, FSM state type and anode helper for the scan decoder
package seg7_pkg;

  // Active-low {a,b,c,d,e,f,g} patterns for digits 0..9
  localparam logic [6:0] SEG7_PAT_0 = 7'b0000001;
  localparam logic [6:0] SEG7_PAT_1 = 7'b1001111;
  localparam logic [6:0] SEG7_PAT_2 = 7'b0010010;
  localparam logic [6:0] SEG7_PAT_3 = 7'b0000110;
  localparam logic [6:0] SEG7_PAT_4 = 7'b1001100;
  localparam logic [6:0] SEG7_PAT_5 = 7'b0100100;
  localparam logic [6:0] SEG7_PAT_6 = 7'b0100000;
  localparam logic [6:0] SEG7_PAT_7 = 7'b0001111;
  localparam logic [6:0] SEG7_PAT_8 = 7'b0000000;
  localparam logic [6:0] SEG7_PAT_9 = 7'b0000100;

  localparam logic [3:0] SEG7_DIGIT_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    CAPTURED = 2'd2
  } seg7_state_e;

  function automatic logic an_onehot_low(input logic [3:0] an);
    return $onehot(~an);
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational active-low segment pattern to BCD digit, dp and invalid flag
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [7:0] seg,
  output logic [3:0] digit,
  output logic       dp,
  output logic       invalid
);

  always_comb begin
    invalid = 1'b0;
    case (seg[7:1])
      SEG7_PAT_0: digit = 4'd0;
      SEG7_PAT_1: digit = 4'd1;
      SEG7_PAT_2: digit = 4'd2;
      SEG7_PAT_3: digit = 4'd3;
      SEG7_PAT_4: digit = 4'd4;
      SEG7_PAT_5: digit = 4'd5;
      SEG7_PAT_6: digit = 4'd6;
      SEG7_PAT_7: digit = 4'd7;
      SEG7_PAT_8: digit = 4'd8;
      SEG7_PAT_9: digit = 4'd9;
      default: begin
        digit   = SEG7_DIGIT_INVALID;
        invalid = 1'b1;
      end
    endcase
  end

  assign dp = ~seg[0];

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - multiplexed 4-digit display bus receiver; optional error counter via SEG7_DEC_ERRCNT_EN
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYC  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  output logic [15:0] bcd,
  output logic [3:0]  dp_o,
  output logic        frame_err,
  output logic        frame_vld,
  output logic [7:0]  err_cnt
);

  localparam int CW = $clog2(STABLE_CYC + 1);

  logic [SYNC_STAGES-1:0][11:0] sync_q;
  logic [11:0]                  s;
  logic [11:0]                  s_prev;
  logic                         changed;
  logic                         legal;

  seg7_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          capture;

  logic [3:0] dec_digit;
  logic       dec_dp;
  logic       dec_invalid;

  logic [3:0][3:0] slot_digit;
  logic [3:0]      slot_dp;
  logic [3:0]      slot_inv;
  logic [3:0]      mask;
  logic [3:0]      cap_bit;
  logic            frame_go;

  // Idle bus level is all-ones, so presetting the synchronizer avoids a false first change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      s_prev <= '1;
    end else begin
      sync_q[0] <= {an, seg};
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      s_prev <= s;
    end
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign changed = (s != s_prev);
  assign legal   = an_onehot_low(s[11:8]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (legal) begin
          state_d = SETTLE;
          cnt_d   = CW'(1);
        end
      end
      SETTLE: begin
        if (changed) begin
          cnt_d   = CW'(1);
          state_d = legal ? SETTLE : IDLE;
        end else if (cnt_q == CW'(STABLE_CYC - 1)) begin
          cnt_d   = CW'(STABLE_CYC);
          state_d = CAPTURED;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CAPTURED: begin
        if (changed) begin
          cnt_d   = CW'(1);
          state_d = legal ? SETTLE : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    capture = 1'b0;
    if (state_q == SETTLE && !changed && cnt_q == CW'(STABLE_CYC - 1)) begin
      capture = 1'b1;
    end
  end

  seg7_pattern_decode u_decode (
    .seg     (s[7:0]),
    .digit   (dec_digit),
    .dp      (dec_dp),
    .invalid (dec_invalid)
  );

  // Anodes are one-hot-low whenever a capture fires, so the inverted bus is the slot select
  assign cap_bit  = capture ? ~s[11:8] : 4'b0000;
  assign frame_go = (mask == 4'b1111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_digit <= '0;
      slot_dp    <= '0;
      slot_inv   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cap_bit[i]) begin
          slot_digit[i] <= dec_digit;
          slot_dp[i]    <= dec_dp;
          slot_inv[i]   <= dec_invalid;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask      <= '0;
      frame_vld <= 1'b0;
      bcd       <= '0;
      dp_o      <= '0;
      frame_err <= 1'b0;
    end else begin
      mask      <= (frame_go ? 4'b0000 : mask) | cap_bit;
      frame_vld <= frame_go;
      if (frame_go) begin
        bcd       <= slot_digit;
        dp_o      <= slot_dp;
        frame_err <= |slot_inv;
      end
    end
  end

`ifdef SEG7_DEC_ERRCNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (capture && dec_invalid && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule
